// File: rtl/memory_access_unit.sv
// Memory-stage access unit for the dual-lane pipeline: serialises dual memory
// accesses onto one synchronous port (lane 1 first) and returns extended load data.
module memory_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ValidM1,
    input  logic        ValidM2,
    input  logic        MemReadM1,
    input  logic        MemReadM2,
    input  logic        MemWriteM1,
    input  logic        MemWriteM2,
    input  logic [2:0]  SizeM1,
    input  logic [2:0]  SizeM2,
    input  logic [31:0] ALUResultM1,
    input  logic [31:0] ALUResultM2,
    input  logic [31:0] WriteDataM1,
    input  logic [31:0] WriteDataM2,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemByteEn,
    output logic        MemWE,
    output logic        MemRE,
    input  logic [31:0] MemRData,
    output logic        StallM,
    output logic [31:0] ReadDataW1,
    output logic [31:0] ReadDataW2,
    output logic        MisalignW1,
    output logic        MisalignW2,
    output logic        o_dbg_state
);
    typedef enum logic {S_IDLE = 1'b0, S_SECOND = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_mis1, w_mis2, w_req1, w_req2;
    logic        w_issue, w_sel2, w_is_load, w_is_store;
    logic [31:0] w_addr, w_data, w_shift, w_ext;
    logic [2:0]  w_size;
    logic        r_ld_valid, r_ld_lane2, r_hold_valid;
    logic [1:0]  r_ld_off;
    logic [2:0]  r_ld_size;
    logic [31:0] r_hold;

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
        return ((size[1:0] == 2'b01) && off[0]) || ((size[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    assign w_mis1 = misaligned(SizeM1, ALUResultM1[1:0]);
    assign w_mis2 = misaligned(SizeM2, ALUResultM2[1:0]);
    assign w_req1 = ValidM1 & (MemReadM1 | MemWriteM1) & ~w_mis1;
    assign w_req2 = ValidM2 & (MemReadM2 | MemWriteM2) & ~w_mis2;
    assign o_dbg_state = r_state;

    always_comb begin
        w_next_state = r_state;
        StallM       = 1'b0;
        w_issue      = 1'b0;
        w_sel2       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req1 && w_req2) begin
                    w_issue      = 1'b1;
                    StallM       = 1'b1;
                    w_next_state = S_SECOND;
                end else if (w_req1) begin
                    w_issue = 1'b1;
                end else if (w_req2) begin
                    w_issue = 1'b1;
                    w_sel2  = 1'b1;
                end
            end
            S_SECOND: begin
                // EX/MEM is held by the stall, so lane 2 is still presented unchanged.
                w_next_state = S_IDLE;
                w_issue      = w_req2;
                w_sel2       = 1'b1;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (!rst_n) begin
            w_issue      = 1'b0;
            StallM       = 1'b0;
            w_next_state = S_IDLE;
        end
    end

    assign w_addr     = w_sel2 ? ALUResultM2 : ALUResultM1;
    assign w_data     = w_sel2 ? WriteDataM2 : WriteDataM1;
    assign w_size     = w_sel2 ? SizeM2 : SizeM1;
    assign w_is_load  = w_sel2 ? MemReadM2 : MemReadM1;
    assign w_is_store = w_sel2 ? MemWriteM2 : MemWriteM1;

    always_comb begin
        MemAddr   = 32'h0;
        MemWData  = 32'h0;
        MemByteEn = 4'b0000;
        MemWE     = 1'b0;
        MemRE     = 1'b0;
        if (w_issue) begin
            MemAddr = {w_addr[31:2], 2'b00};
            if (w_is_load) begin
                MemRE = 1'b1;
            end else if (w_is_store) begin
                MemWE = 1'b1;
                case (w_size[1:0])
                    2'b00: begin
                        MemByteEn = 4'b0001 << w_addr[1:0];
                        MemWData  = {4{w_data[7:0]}};
                    end
                    2'b01: begin
                        MemByteEn = 4'b0011 << w_addr[1:0];
                        MemWData  = {2{w_data[15:0]}};
                    end
                    default: begin
                        MemByteEn = 4'b1111;
                        MemWData  = w_data;
                    end
                endcase
            end
        end
    end

    // Load return uses the offset/size captured at issue, not the current M inputs.
    assign w_shift = MemRData >> {r_ld_off, 3'b000};
    always_comb begin
        case (r_ld_size)
            3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ext = {24'h0, w_shift[7:0]};
            3'b101:  w_ext = {16'h0, w_shift[15:0]};
            default: w_ext = MemRData;
        endcase
    end

    assign ReadDataW1 = r_hold_valid ? r_hold :
                        (r_ld_valid && !r_ld_lane2) ? w_ext : 32'h0;
    assign ReadDataW2 = (r_ld_valid && r_ld_lane2) ? w_ext : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ld_valid   <= 1'b0;
            r_ld_lane2   <= 1'b0;
            r_ld_off     <= 2'b00;
            r_ld_size    <= 3'b000;
            r_hold_valid <= 1'b0;
            r_hold       <= 32'h0;
            MisalignW1   <= 1'b0;
            MisalignW2   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_ld_valid   <= w_issue & w_is_load;
            r_ld_lane2   <= w_sel2;
            r_ld_off     <= w_addr[1:0];
            r_ld_size    <= w_size;
            // Lane 1 data returns while lane 2 is being issued; park it until both reach W.
            r_hold_valid <= (r_state == S_SECOND) & r_ld_valid & ~r_ld_lane2;
            if ((r_state == S_SECOND) && r_ld_valid && !r_ld_lane2)
                r_hold <= w_ext;
            MisalignW1   <= ValidM1 & (MemReadM1 | MemWriteM1) & w_mis1;
            MisalignW2   <= ValidM2 & (MemReadM2 | MemWriteM2) & w_mis2;
        end
    end
endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a behavioural synchronous data memory.
module tb_memory_access_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidM1, ValidM2, MemReadM1, MemReadM2, MemWriteM1, MemWriteM2;
    logic [2:0]  SizeM1, SizeM2;
    logic [31:0] ALUResultM1, ALUResultM2, WriteDataM1, WriteDataM2;
    logic [31:0] MemAddr, MemWData, MemRData;
    logic [3:0]  MemByteEn;
    logic        MemWE, MemRE, StallM, MisalignW1, MisalignW2, dbg_state;
    logic [31:0] ReadDataW1, ReadDataW2;
    logic [31:0] mem [0:1023];
    int          tests_run = 0;
    int          tests_failed = 0;

    memory_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .ValidM1(ValidM1), .ValidM2(ValidM2),
        .MemReadM1(MemReadM1), .MemReadM2(MemReadM2),
        .MemWriteM1(MemWriteM1), .MemWriteM2(MemWriteM2),
        .SizeM1(SizeM1), .SizeM2(SizeM2),
        .ALUResultM1(ALUResultM1), .ALUResultM2(ALUResultM2),
        .WriteDataM1(WriteDataM1), .WriteDataM2(WriteDataM2),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemByteEn(MemByteEn),
        .MemWE(MemWE), .MemRE(MemRE), .MemRData(MemRData),
        .StallM(StallM), .ReadDataW1(ReadDataW1), .ReadDataW2(ReadDataW2),
        .MisalignW1(MisalignW1), .MisalignW2(MisalignW2), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (MemWE)
            for (int b = 0; b < 4; b++)
                if (MemByteEn[b]) mem[MemAddr[11:2]][8*b +: 8] <= MemWData[8*b +: 8];
        if (MemRE) MemRData <= mem[MemAddr[11:2]];
    end

    task automatic set_idle();
        ValidM1 = 0; ValidM2 = 0; MemReadM1 = 0; MemReadM2 = 0;
        MemWriteM1 = 0; MemWriteM2 = 0; SizeM1 = 3'b010; SizeM2 = 3'b010;
        ALUResultM1 = 0; ALUResultM2 = 0; WriteDataM1 = 0; WriteDataM2 = 0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        set_idle();
        ValidM1 = 1; MemReadM1 = 1; ALUResultM1 = 32'h100;
        ValidM2 = 1; MemReadM2 = 1; ALUResultM2 = 32'h104;
        next_cycle();
        next_cycle();
        tests_run++;
        if ({MemRE, MemWE, StallM} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_strobes: got %b expected 000", {MemRE, MemWE, StallM});
        end
        tests_run++;
        if ({ReadDataW1, ReadDataW2, MisalignW1, MisalignW2, dbg_state} !== 67'h0) begin
            tests_failed++; $display("FAIL reset_outputs: got %h %h %b%b st=%b expected all 0",
                                     ReadDataW1, ReadDataW2, MisalignW1, MisalignW2, dbg_state);
        end
        set_idle();
        next_cycle();
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_single_lw();
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        ValidM1 = 1; MemReadM1 = 1; SizeM1 = 3'b010; ALUResultM1 = 32'h100;
        ValidM2 = 1; ALUResultM2 = 32'h5;
        #1;
        tests_run++;
        if ({MemRE, MemWE, StallM, MemByteEn} !== 7'b1000000 || MemAddr !== 32'h100) begin
            tests_failed++; $display("FAIL lw_issue: got re=%b we=%b stall=%b be=%b addr=%h expected 1 0 0 0000 00000100",
                                     MemRE, MemWE, StallM, MemByteEn, MemAddr);
        end
        next_cycle();
        set_idle();
        #1;
        tests_run++;
        if (ReadDataW1 !== 32'hDEADBEEF || ReadDataW2 !== 32'h0) begin
            tests_failed++; $display("FAIL lw_data: got %h %h expected deadbeef 00000000", ReadDataW1, ReadDataW2);
        end
        tests_run++;
        if (MemRE !== 1'b0) begin
            tests_failed++; $display("FAIL lw_no_reissue: got re=%b expected 0", MemRE);
        end
        next_cycle();
    endtask

    task automatic test_stores();
        ValidM1 = 1; MemWriteM1 = 1; SizeM1 = 3'b000; ALUResultM1 = 32'h203; WriteDataM1 = 32'h000000A5;
        #1;
        tests_run++;
        if (MemAddr !== 32'h200 || MemByteEn !== 4'b1000 || MemWData !== 32'hA5A5A5A5 ||
            MemWE !== 1'b1 || MemRE !== 1'b0) begin
            tests_failed++; $display("FAIL sb_encode: got addr=%h be=%b wd=%h we=%b re=%b expected 00000200 1000 a5a5a5a5 1 0",
                                     MemAddr, MemByteEn, MemWData, MemWE, MemRE);
        end
        next_cycle();
        set_idle();
        ValidM2 = 1; MemWriteM2 = 1; SizeM2 = 3'b001; ALUResultM2 = 32'h42; WriteDataM2 = 32'h1234BEEF;
        #1;
        tests_run++;
        if (MemAddr !== 32'h40 || MemByteEn !== 4'b1100 || MemWData !== 32'hBEEFBEEF || MemWE !== 1'b1) begin
            tests_failed++; $display("FAIL sh_encode: got addr=%h be=%b wd=%h we=%b expected 00000040 1100 beefbeef 1",
                                     MemAddr, MemByteEn, MemWData, MemWE);
        end
        next_cycle();
        set_idle();
        #1;
        tests_run++;
        if (mem[32'h200 >> 2] !== 32'hA5000000) begin
            tests_failed++; $display("FAIL sb_memory: got %h expected a5000000", mem[32'h200 >> 2]);
        end
        ValidM1 = 0; MemWriteM1 = 1; ALUResultM1 = 32'h300;
        #1;
        tests_run++;
        if (MemWE !== 1'b0 || StallM !== 1'b0) begin
            tests_failed++; $display("FAIL flush_suppress: got we=%b stall=%b expected 0 0", MemWE, StallM);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_dual_loads();
        mem[32'h100 >> 2] = 32'h80018000;
        ValidM1 = 1; MemReadM1 = 1; SizeM1 = 3'b000; ALUResultM1 = 32'h101;
        ValidM2 = 1; MemReadM2 = 1; SizeM2 = 3'b101; ALUResultM2 = 32'h102;
        #1;
        tests_run++;
        if (StallM !== 1'b1 || MemRE !== 1'b1 || MemAddr !== 32'h100 || dbg_state !== 1'b0) begin
            tests_failed++; $display("FAIL dual_first: got stall=%b re=%b addr=%h st=%b expected 1 1 00000100 0",
                                     StallM, MemRE, MemAddr, dbg_state);
        end
        next_cycle();
        tests_run++;
        if (StallM !== 1'b0 || MemRE !== 1'b1 || MemAddr !== 32'h100 || dbg_state !== 1'b1) begin
            tests_failed++; $display("FAIL dual_second: got stall=%b re=%b addr=%h st=%b expected 0 1 00000100 1",
                                     StallM, MemRE, MemAddr, dbg_state);
        end
        next_cycle();
        set_idle();
        #1;
        tests_run++;
        if (ReadDataW1 !== 32'hFFFFFF80 || ReadDataW2 !== 32'h00008001 || StallM !== 1'b0) begin
            tests_failed++; $display("FAIL dual_data: got %h %h stall=%b expected ffffff80 00008001 0",
                                     ReadDataW1, ReadDataW2, StallM);
        end
        next_cycle();
    endtask

    task automatic test_store_then_load();
        ValidM1 = 1; MemWriteM1 = 1; SizeM1 = 3'b010; ALUResultM1 = 32'h40; WriteDataM1 = 32'h12345678;
        ValidM2 = 1; MemReadM2 = 1; SizeM2 = 3'b010; ALUResultM2 = 32'h40;
        #1;
        tests_run++;
        if (MemWE !== 1'b1 || MemRE !== 1'b0 || MemByteEn !== 4'b1111 || MemWData !== 32'h12345678 || StallM !== 1'b1) begin
            tests_failed++; $display("FAIL st_ld_store: got we=%b re=%b be=%b wd=%h stall=%b expected 1 0 1111 12345678 1",
                                     MemWE, MemRE, MemByteEn, MemWData, StallM);
        end
        next_cycle();
        tests_run++;
        if (MemRE !== 1'b1 || MemWE !== 1'b0 || MemAddr !== 32'h40) begin
            tests_failed++; $display("FAIL st_ld_load: got re=%b we=%b addr=%h expected 1 0 00000040", MemRE, MemWE, MemAddr);
        end
        next_cycle();
        set_idle();
        #1;
        tests_run++;
        if (ReadDataW2 !== 32'h12345678 || ReadDataW1 !== 32'h0) begin
            tests_failed++; $display("FAIL st_ld_data: got %h %h expected 00000000 12345678", ReadDataW1, ReadDataW2);
        end
        next_cycle();
    endtask

    task automatic test_misalign();
        mem[32'h104 >> 2] = 32'h0000F00D;
        ValidM1 = 1; MemReadM1 = 1; SizeM1 = 3'b010; ALUResultM1 = 32'h102;
        ValidM2 = 1; MemReadM2 = 1; SizeM2 = 3'b001; ALUResultM2 = 32'h104;
        #1;
        tests_run++;
        if (StallM !== 1'b0 || MemRE !== 1'b1 || MemAddr !== 32'h104) begin
            tests_failed++; $display("FAIL mis_issue: got stall=%b re=%b addr=%h expected 0 1 00000104", StallM, MemRE, MemAddr);
        end
        next_cycle();
        set_idle();
        #1;
        tests_run++;
        if (MisalignW1 !== 1'b1 || MisalignW2 !== 1'b0) begin
            tests_failed++; $display("FAIL mis_flags: got %b%b expected 10", MisalignW1, MisalignW2);
        end
        tests_run++;
        if (ReadDataW2 !== 32'hFFFFF00D || ReadDataW1 !== 32'h0) begin
            tests_failed++; $display("FAIL mis_data: got %h %h expected 00000000 fffff00d", ReadDataW1, ReadDataW2);
        end
        next_cycle();
        tests_run++;
        if (MisalignW1 !== 1'b0) begin
            tests_failed++; $display("FAIL mis_clear: got %b expected 0", MisalignW1);
        end
    endtask

    task automatic test_reset_in_second();
        mem[32'h180 >> 2] = 32'h11223344;
        ValidM1 = 1; MemReadM1 = 1; SizeM1 = 3'b010; ALUResultM1 = 32'h180;
        ValidM2 = 1; MemReadM2 = 1; SizeM2 = 3'b010; ALUResultM2 = 32'h180;
        #1;
        tests_run++;
        if (StallM !== 1'b1) begin
            tests_failed++; $display("FAIL rst2_stall: got %b expected 1", StallM);
        end
        next_cycle();
        rst_n = 0;
        #1;
        tests_run++;
        if (MemRE !== 1'b0 || StallM !== 1'b0) begin
            tests_failed++; $display("FAIL rst2_no_issue: got re=%b stall=%b expected 0 0", MemRE, StallM);
        end
        next_cycle();
        rst_n = 1;
        set_idle();
        #1;
        tests_run++;
        if (dbg_state !== 1'b0 || StallM !== 1'b0 || MemRE !== 1'b0 ||
            ReadDataW1 !== 32'h0 || ReadDataW2 !== 32'h0) begin
            tests_failed++; $display("FAIL rst2_after: got st=%b stall=%b re=%b rd1=%h rd2=%h expected 0 0 0 0 0",
                                     dbg_state, StallM, MemRE, ReadDataW1, ReadDataW2);
        end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        MemRData = 32'h0;
        test_reset();
        test_single_lw();
        test_stores();
        test_dual_loads();
        test_store_then_load();
        test_misalign();
        test_reset_in_second();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory-stage access unit for the dual-lane pipeline: consumes both lanes' execute results (ALU result as address, forwarded store data) from the EX/MEM register and drives a single-port synchronous data memory. Lane 1 is older in program order. When both lanes need memory in the same cycle, the unit serialises them (lane 1 first) and stalls the front of the pipeline for one cycle. It also returns load data to writeback, sign- or zero-extended and byte-aligned.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous, active-low reset
- ValidM1, ValidM2  in  1  lane holds a live instruction in M
- MemReadM1, MemReadM2  in  1  lane is a load
- MemWriteM1, MemWriteM2  in  1  lane is a store
- SizeM1, SizeM2  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ALUResultM1, ALUResultM2  in  32  byte address
- WriteDataM1, WriteDataM2  in  32  store data (already forwarded in execute)
- MemAddr  out  32  word address, bits [1:0] = 0
- MemWData  out  32  lane-aligned store data
- MemByteEn  out  4  byte write enables
- MemWE, MemRE  out  1  write / read strobe
- MemRData  in  32  read word; valid in the cycle after MemRE
- StallM  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- ReadDataW1, ReadDataW2  out  32  extended load data for the W stage
- MisalignW1, MisalignW2  out  1  registered misaligned-access flag for the W stage

## Operation
- Lane i requests access when `ValidMi & (MemReadMi | MemWriteMi) & ~misalign_i`.
- Misaligned: h/hu with addr[0]=1; w with addr[1:0]≠0. A misaligned access issues no memory strobe and never stalls. The flag is registered to MisalignWi.
- FSM states:
  - IDLE
    - One lane requests: issue it; StallM=0; stay in IDLE.
    - Both lanes request: issue lane 1; StallM=1; go to SECOND.
    - No lane requests: all strobes 0.
  - SECOND: issue lane 2; StallM=0; return to IDLE.
  - Lane 1 is never reissued in SECOND.
- Store encoding, with off = addr[1:0]:
  - sb: MemByteEn = 0001<<off; MemWData = data[7:0] replicated ×4.
  - sh: MemByteEn = 0011<<off; MemWData = data[15:0] replicated ×2.
  - sw: MemByteEn = 1111; MemWData = data.
- Loads: MemRE=1, MemByteEn=0000, MemWE=0. MemWE and MemRE are never both 1.
- Load return:
  - The offset, size and owning lane are registered at issue.
  - The byte/half is selected from MemRData by the registered offset, then sign-extended (b, h) or zero-extended (bu, hu).
- Serialised case: lane 1 load data arrives in the SECOND cycle and is captured into a hold register at that cycle's edge. In the following W cycle:
  - ReadDataW1 = hold register.
  - ReadDataW2 = extended MemRData (combinational).
- Non-serialised case: the issuing lane's ReadDataWi = extended MemRData (combinational).
- Lanes with no load in W: ReadDataWi = 0.
- Program order is preserved: a lane-1 store followed by a lane-2 load to the same word returns the stored value.
- Reset: state IDLE, StallM=0, all strobes 0, hold register 0, MisalignW1/2 = 0, ReadDataW1/2 = 0.

## Timing
- Single access issued in cycle N: memory strobe in N; data (for a load) in N+1; ReadDataWi valid in N+1 while the instruction is in W.
- Dual access detected in cycle N:
  - Lane 1 strobe in N; StallM=1 in N.
  - Lane 2 strobe in N+1; StallM=0 in N+1.
  - Both lanes enter W at N+2; both ReadDataW valid in N+2.
- StallM depends combinationally on the M-stage inputs and state. It is asserted for at most one cycle per instruction pair.
- The EX/MEM inputs are held stable by StallM during SECOND. The unit reads lane 2 from them unchanged.
- Reset asserted in SECOND: lane 2 is not issued; next state IDLE; no hold-register update.
- ValidMi=0 suppresses a lane's access regardless of its other controls. This is how a flush enters the stage.

## Test plan
- Lane 1 `lw` from 0x100 (mem = 0xDEADBEEF), lane 2 ALU op → one MemRE at addr 0x100, StallM=0, ReadDataW1 = 0xDEADBEEF next cycle.
- Lane 1 `sb` of 0x000000A5 to 0x203, lane 2 idle → MemAddr = 0x200, MemByteEn = 1000, MemWData = 0xA5A5A5A5, MemWE=1.
- Lane 1 `lb` from 0x101 (byte 0x80), lane 2 `lhu` from 0x102 (half 0x8001), same cycle → StallM=1 for exactly one cycle; two reads in consecutive cycles; ReadDataW1 = 0xFFFFFF80 and ReadDataW2 = 0x00008001 in the same W cycle.
- Lane 1 `sw` 0x12345678 to 0x40, lane 2 `lw` from 0x40 → store precedes load; ReadDataW2 = 0x12345678.
- Lane 1 `lw` at 0x102 (misaligned), lane 2 `lh` at 0x104 → no stall; only lane 2 accesses memory; MisalignW1=1, MisalignW2=0.
- Dual loads with rst_n=0 during SECOND → next cycle state IDLE, StallM=0, no MemRE, ReadDataW1/2 = 0.
